// File: rtl/dq_pkg.sv
// ============================================================================
// Module  : dq_pkg
// Brief   : Shared class encoding, unit indices and default sizes for the
//           dispatch queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dq_pkg;

  typedef enum logic [1:0] {
    CLS_FXU = 2'b00,
    CLS_LSU = 2'b01,
    CLS_BR  = 2'b10,
    CLS_NOP = 2'b11
  } dq_class_e;

  localparam int NUM_UNITS = 4;
  localparam int UNIT_FXU0 = 0;
  localparam int UNIT_FXU1 = 1;
  localparam int UNIT_LSU  = 2;
  localparam int UNIT_BR   = 3;

  localparam int DQ_DEPTH   = 8;
  localparam int DQ_FETCH_W = 4;
  localparam int DQ_XLEN    = 16;
  localparam int DQ_TAG_W   = 4;

endpackage

`default_nettype wire

// File: rtl/dq_issue_select.sv
// ============================================================================
// Module  : dq_issue_select
// Brief   : In-order unit selection over the FETCH_W oldest queue entries.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dq_issue_select
  import dq_pkg::*;
#(
  parameter int FETCH_W = DQ_FETCH_W,
  parameter int SLOT_W  = (FETCH_W > 1) ? $clog2(FETCH_W) : 1,
  parameter int CNT_W   = $clog2(FETCH_W + 1)
) (
  input  logic [FETCH_W*2-1:0]         cls,
  input  logic [FETCH_W-1:0]           vld,
  input  logic [NUM_UNITS-1:0]         unit_full,
  output logic [NUM_UNITS*SLOT_W-1:0]  slot,
  output logic [NUM_UNITS-1:0]         slot_valid,
  output logic [CNT_W-1:0]             disp_cnt
);

  logic                 w_stop;
  logic [NUM_UNITS-1:0] w_taken;
  logic [NUM_UNITS-1:0] w_free;
  logic [NUM_UNITS-1:0] w_pick;
  dq_class_e            w_cls;

  // The first entry that finds no unit ends the scan so younger entries never
  // overtake it.
  always_comb begin
    w_stop   = 1'b0;
    w_taken  = '0;
    w_free   = '0;
    w_pick   = '0;
    w_cls    = CLS_NOP;
    slot     = '0;
    disp_cnt = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      w_cls  = dq_class_e'(cls[i*2 +: 2]);
      w_free = ~unit_full & ~w_taken;
      w_pick = '0;
      if (!w_stop) begin
        if (!vld[i]) begin
          w_stop = 1'b1;
        end else begin
          case (w_cls)
            CLS_FXU: begin
              if (w_free[UNIT_FXU0])      w_pick[UNIT_FXU0] = 1'b1;
              else if (w_free[UNIT_FXU1]) w_pick[UNIT_FXU1] = 1'b1;
            end
            CLS_LSU: if (w_free[UNIT_LSU]) w_pick[UNIT_LSU] = 1'b1;
            CLS_BR:  if (w_free[UNIT_BR])  w_pick[UNIT_BR]  = 1'b1;
            default: ;
          endcase
          if (w_pick == '0) begin
            w_stop = 1'b1;
          end else begin
            w_taken  = w_taken | w_pick;
            disp_cnt = disp_cnt + CNT_W'(1);
            for (int u = 0; u < NUM_UNITS; u++) begin
              if (w_pick[u]) slot[u*SLOT_W +: SLOT_W] = SLOT_W'(i);
            end
          end
        end
      end
    end
    slot_valid = w_taken;
  end

endmodule

`default_nettype wire

// File: rtl/dispatch_queue.sv
// ============================================================================
// Module  : dispatch_queue
// Brief   : Circular in-order dispatch queue with CDB wakeup/bypass feeding
//           FXU0/FXU1/LSU/BR execution units.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatch_queue
  import dq_pkg::*;
#(
  parameter int DEPTH   = DQ_DEPTH,
  parameter int FETCH_W = DQ_FETCH_W,
  parameter int XLEN    = DQ_XLEN,
  parameter int TAG_W   = DQ_TAG_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  output logic                          in_ready,
  input  logic [$clog2(FETCH_W+1)-1:0]  in_count,
  input  logic [FETCH_W*2-1:0]          in_class,
  input  logic [FETCH_W-1:0]            in_a_rdy,
  input  logic [FETCH_W-1:0]            in_b_rdy,
  input  logic [FETCH_W*TAG_W-1:0]      in_a_tag,
  input  logic [FETCH_W*TAG_W-1:0]      in_b_tag,
  input  logic [FETCH_W*XLEN-1:0]       in_a_val,
  input  logic [FETCH_W*XLEN-1:0]       in_b_val,
  input  logic [FETCH_W*TAG_W-1:0]      in_rt,
  input  logic                          cdb_valid,
  input  logic [TAG_W-1:0]              cdb_tag,
  input  logic [XLEN-1:0]               cdb_value,
  input  logic [NUM_UNITS-1:0]          unit_full,
  output logic [NUM_UNITS-1:0]          out_valid,
  output logic [NUM_UNITS-1:0]          out_a_rdy,
  output logic [NUM_UNITS-1:0]          out_b_rdy,
  output logic [NUM_UNITS*TAG_W-1:0]    out_a_tag,
  output logic [NUM_UNITS*TAG_W-1:0]    out_b_tag,
  output logic [NUM_UNITS*XLEN-1:0]     out_a_val,
  output logic [NUM_UNITS*XLEN-1:0]     out_b_val,
  output logic [NUM_UNITS*TAG_W-1:0]    out_rt,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ICNT_W = $clog2(FETCH_W + 1);
  localparam int SLOT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

  // Entry storage
  logic [1:0]       r_cls   [DEPTH];
  logic [TAG_W-1:0] r_a_tag [DEPTH];
  logic [TAG_W-1:0] r_b_tag [DEPTH];
  logic [TAG_W-1:0] r_rt    [DEPTH];
  logic [XLEN-1:0]  r_a_val [DEPTH];
  logic [XLEN-1:0]  r_b_val [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_a_rdy;
  logic [DEPTH-1:0] r_b_rdy;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;

  logic [CNT_W-1:0]            w_count;
  logic [IDX_W-1:0]            w_head_idx;
  logic [IDX_W-1:0]            w_tail_idx;
  logic [DEPTH-1:0]            w_a_hit;
  logic [DEPTH-1:0]            w_b_hit;
  logic [FETCH_W-1:0]          w_lane_a_hit;
  logic [FETCH_W-1:0]          w_lane_b_hit;
  logic [FETCH_W*2-1:0]        w_scan_cls;
  logic [FETCH_W-1:0]          w_scan_vld;
  logic [NUM_UNITS*SLOT_W-1:0] w_slot;
  logic [NUM_UNITS-1:0]        w_sel_valid;
  logic [ICNT_W-1:0]           w_disp_cnt;
  logic [IDX_W-1:0]            w_disp_idx [NUM_UNITS];
  logic                        w_enq_fire;
  logic [FETCH_W-1:0]          w_lane_en;
  logic [IDX_W-1:0]            w_wr_idx   [FETCH_W];
  logic [ICNT_W-1:0]           w_enq_cnt;

  // The extra pointer MSB tells a full queue apart from an empty one.
  assign w_count    = CNT_W'(r_tail - r_head);
  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign occupancy  = w_count;
  assign in_ready   = (w_count <= CNT_W'(DEPTH - FETCH_W));
  assign w_enq_fire = in_ready && (in_count != '0) && !flush && !rst;

  for (genvar e = 0; e < DEPTH; e++) begin : g_hit
    assign w_a_hit[e] = cdb_valid && !r_a_rdy[e] && (r_a_tag[e] == cdb_tag);
    assign w_b_hit[e] = cdb_valid && !r_b_rdy[e] && (r_b_tag[e] == cdb_tag);
  end

  for (genvar l = 0; l < FETCH_W; l++) begin : g_lane
    assign w_lane_a_hit[l] = cdb_valid && !in_a_rdy[l] && (in_a_tag[l*TAG_W +: TAG_W] == cdb_tag);
    assign w_lane_b_hit[l] = cdb_valid && !in_b_rdy[l] && (in_b_tag[l*TAG_W +: TAG_W] == cdb_tag);
  end

  // Only entries counted at the last edge are scanned, so this cycle's
  // enqueues wait a cycle before they can dispatch.
  always_comb begin
    w_scan_cls = '0;
    w_scan_vld = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      w_scan_cls[i*2 +: 2] = r_cls[w_head_idx + IDX_W'(i)];
      w_scan_vld[i]        = !rst && !flush && (CNT_W'(i) < w_count);
    end
  end

  dq_issue_select #(
    .FETCH_W (FETCH_W),
    .SLOT_W  (SLOT_W),
    .CNT_W   (ICNT_W)
  ) u_select (
    .cls        (w_scan_cls),
    .vld        (w_scan_vld),
    .unit_full  (unit_full),
    .slot       (w_slot),
    .slot_valid (w_sel_valid),
    .disp_cnt   (w_disp_cnt)
  );

  always_comb begin
    out_valid = w_sel_valid;
    out_a_rdy = '0;
    out_b_rdy = '0;
    out_a_tag = '0;
    out_b_tag = '0;
    out_a_val = '0;
    out_b_val = '0;
    out_rt    = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      w_disp_idx[u] = w_head_idx + IDX_W'(w_slot[u*SLOT_W +: SLOT_W]);
      if (w_sel_valid[u]) begin
        out_a_rdy[u]                = r_a_rdy[w_disp_idx[u]] | w_a_hit[w_disp_idx[u]];
        out_b_rdy[u]                = r_b_rdy[w_disp_idx[u]] | w_b_hit[w_disp_idx[u]];
        out_a_tag[u*TAG_W +: TAG_W] = r_a_tag[w_disp_idx[u]];
        out_b_tag[u*TAG_W +: TAG_W] = r_b_tag[w_disp_idx[u]];
        out_a_val[u*XLEN +: XLEN]   = w_a_hit[w_disp_idx[u]] ? cdb_value : r_a_val[w_disp_idx[u]];
        out_b_val[u*XLEN +: XLEN]   = w_b_hit[w_disp_idx[u]] ? cdb_value : r_b_val[w_disp_idx[u]];
        out_rt[u*TAG_W +: TAG_W]    = r_rt[w_disp_idx[u]];
      end
    end
  end

  // NOP lanes are squeezed out: each live lane lands after the previous one.
  always_comb begin
    w_enq_cnt = '0;
    w_lane_en = '0;
    for (int l = 0; l < FETCH_W; l++) begin
      w_wr_idx[l] = w_tail_idx + IDX_W'(w_enq_cnt);
      if (w_enq_fire && (ICNT_W'(l) < in_count) && (in_class[l*2 +: 2] != CLS_NOP)) begin
        w_lane_en[l] = 1'b1;
        w_enq_cnt    = w_enq_cnt + ICNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
    end else begin
      r_head <= r_head + PTR_W'(w_disp_cnt);
      r_tail <= r_tail + PTR_W'(w_enq_cnt);
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (out_valid[u]) r_valid[w_disp_idx[u]] <= 1'b0;
      end
      for (int l = 0; l < FETCH_W; l++) begin
        if (w_lane_en[l]) r_valid[w_wr_idx[l]] <= 1'b1;
      end
    end
  end

  // Payload needs no reset: r_valid and the pointers gate every use of it.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (r_valid[e] && w_a_hit[e]) begin
          r_a_rdy[e] <= 1'b1;
          r_a_val[e] <= cdb_value;
        end
        if (r_valid[e] && w_b_hit[e]) begin
          r_b_rdy[e] <= 1'b1;
          r_b_val[e] <= cdb_value;
        end
      end
      for (int l = 0; l < FETCH_W; l++) begin
        if (w_lane_en[l]) begin
          r_cls[w_wr_idx[l]]   <= in_class[l*2 +: 2];
          r_a_rdy[w_wr_idx[l]] <= in_a_rdy[l] | w_lane_a_hit[l];
          r_b_rdy[w_wr_idx[l]] <= in_b_rdy[l] | w_lane_b_hit[l];
          r_a_tag[w_wr_idx[l]] <= in_a_tag[l*TAG_W +: TAG_W];
          r_b_tag[w_wr_idx[l]] <= in_b_tag[l*TAG_W +: TAG_W];
          r_a_val[w_wr_idx[l]] <= w_lane_a_hit[l] ? cdb_value : in_a_val[l*XLEN +: XLEN];
          r_b_val[w_wr_idx[l]] <= w_lane_b_hit[l] ? cdb_value : in_b_val[l*XLEN +: XLEN];
          r_rt[w_wr_idx[l]]    <= in_rt[l*TAG_W +: TAG_W];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH, 8, entries (power of 2, >= FETCH_W)
- FETCH_W, 4, enqueue lanes per cycle
- XLEN, 16, operand width
- TAG_W, 4, ROB tag width
REQ-002 The block SHALL have one clock and synchronous active-high reset, with ports in this order:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries
- in_ready  out  1  (DEPTH-count) >= FETCH_W
- in_count  in  $clog2(FETCH_W+1)  valid lanes 0..in_count-1 this cycle
- in_class  in  FETCH_W*2  00 FXU, 01 LSU, 10 BR, 11 NOP (dropped)
- in_a_rdy, in_b_rdy  in  FETCH_W  operand value present
- in_a_tag, in_b_tag  in  FETCH_W*TAG_W  producing ROB tag when not ready
- in_a_val, in_b_val  in  FETCH_W*XLEN  operand value when ready
- in_rt  in  FETCH_W*TAG_W  destination ROB tag
- cdb_valid  in  1  completion broadcast valid
- cdb_tag  in  TAG_W  completing ROB tag
- cdb_value  in  XLEN  completing value
- unit_full  in  4  per unit {BR, LSU, FXU1, FXU0}, bit0 = FXU0
- out_valid  out  4  per-unit dispatch this cycle
- out_a_rdy, out_b_rdy  out  4  operand ready
- out_a_tag, out_b_tag  out  4*TAG_W  operand tag
- out_a_val, out_b_val  out  4*XLEN  operand value
- out_rt  out  4*TAG_W  destination tag
- occupancy  out  $clog2(DEPTH+1)  valid entries

Function
REQ-003 Enqueue SHALL occur when in_ready=1 and in_count>0: lanes 0..in_count-1 written at tail in lane order; NOP lanes consume no entry; tail advances by non-NOP count mod DEPTH.
REQ-004 in_count>0 with in_ready=0 SHALL be ignored; fetch holds.
REQ-005 in_ready SHALL be computed from registered count only; slots freed by dispatch become usable the next cycle.
REQ-006 Enqueued entries SHALL become dispatchable no earlier than the next cycle.
REQ-007 Dispatch SHALL be in order: scan head..head+FETCH_W-1; an entry dispatches only if every older scanned entry dispatches; stop at the first entry with no unit.
REQ-008 FXU entries SHALL go to FXU0 if not full and not yet taken this cycle, else to FXU1 if not full and not taken; LSU to LSU, BR to BR; at most one entry per unit per cycle.
REQ-009 Dispatch SHALL NOT wait for operand readiness; rdy/tag/val pass through to the unit.
REQ-010 out_valid SHALL be a combinational function of registered state, unit_full and flush; it may depend on any unit_full bit; head advances by the dispatched count.
REQ-011 Wakeup: a valid entry with x_rdy=0 and x_tag==cdb_tag while cdb_valid=1 SHALL set x_rdy=1 and x_val=cdb_value at the edge.
REQ-012 Same-cycle bypass: the CDB match SHALL also apply to entries dispatched that cycle (outputs show rdy=1 and the CDB value) and to lanes enqueued that cycle.
REQ-013 Wrap-around: head and tail SHALL be log2(DEPTH)+1 bits; full/empty SHALL be distinguished by the MSB.
REQ-014 With flush=1, out_valid SHALL be 0 that cycle; head, tail and count SHALL be 0 next cycle; flush SHALL override enqueue and wakeup.
REQ-015 Non-dispatching out_* fields SHALL be driven to 0.

Reset
REQ-016 When rst=1 at an edge: head=tail=count=0 and all entry valid bits cleared. After reset: out_valid=0, in_ready=1, occupancy=0, all out_* data fields 0.
REQ-017 Reset mid-operation SHALL drop all entries without dispatching them; reset SHALL take priority over flush.

Structure
REQ-018 Package dq_pkg SHALL hold the class encoding, unit indices (FXU0=0, FXU1=1, LSU=2, BR=3), NUM_UNITS=4 and default parameter values.
REQ-019 Unit selection SHALL be a combinational sub-module, dq_issue_select (inputs: classes and valids of the FETCH_W oldest entries plus unit_full; outputs: per-unit slot index, valid and dispatch count). Storage and pointers SHALL stay in dispatch_queue.

Verification
REQ-020 Reset, then 4 FXU lanes, units free -> next cycle FXU0=entry0, FXU1=entry1, occupancy 4->2->0 over two cycles.
REQ-021 Order BR, FXU, BR, LSU with BR free -> cycle 1 dispatches BR+FXU0 only (second BR blocks LSU); the remaining BR and LSU dispatch the next cycle.
REQ-022 Entry waiting on a_tag=5; cdb_valid=1, tag=5, value=0xBEEF in its dispatch cycle -> out_a_rdy=1, out_a_val=0xBEEF.
REQ-023 DEPTH=8, unit_full=4'hF, enqueue 4 then 4 -> in_ready=0 at occupancy 8; release units across wrap -> order preserved.
REQ-024 flush together with in_count=4 and unit_full=0 -> no out_valid that cycle; occupancy 0 next cycle; enqueue ignored.
